// File: rtl/cla_seq_adder_ctrl.sv
// Sequential add/subtract controller: one 4-bit carry-lookahead slice is stepped
// across the operand nibbles, with the inter-nibble carry kept in a register.

module carry_lookahead_adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p    = a_i ^ b_i;
    assign g    = a_i & b_i;
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o  = p ^ c[3:0];
    assign cout_o = c[4];
endmodule

module cla_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               carry_q;
    logic               cout_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               last;
    logic [3:0]         sl_a;
    logic [3:0]         sl_b;
    logic [3:0]         sl_sum;
    logic               sl_cout;

    assign sl_a  = opa_q[4*idx_q +: 4];
    assign sl_b  = opb_q[4*idx_q +: 4];
    assign last  = (idx_q == IDX_W'(NIB - 1));
    assign idx_d = idx_q + 1'b1;

    carry_lookahead_adder_4bit u_slice (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .cin_i  (carry_q),
        .sum_o  (sl_sum),
        .cout_o (sl_cout)
    );

    always_comb begin
        sum_d = sum_q;
        sum_d[4*idx_q +: 4] = sl_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1, so the slice only ever adds.
                        opa_q      <= a;
                        opb_q      <= sub ? ~b : b;
                        carry_q    <= sub ? 1'b1 : cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= sl_cout;
                    idx_q   <= idx_d;
                    if (last) begin
                        cout_q      <= sl_cout;
                        ovf_q       <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                                       (sl_sum[3] != opa_q[WIDTH-1]);
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Bench for cla_seq_adder_ctrl: directed corner cases plus random operations
// checked against an integer-arithmetic reference model.

module tb_cla_seq_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                         input logic tsub, output logic [W-1:0] esum, output logic ecout,
                         output logic eovf);
        logic [W:0] full;
        int         sr;
        if (tsub) begin
            esum  = ta - tb_;
            ecout = (ta >= tb_);
            sr    = int'($signed(ta)) - int'($signed(tb_));
        end else begin
            full  = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tcin);
            esum  = full[W-1:0];
            ecout = full[W];
            sr    = int'($signed(ta)) + int'($signed(tb_)) + int'(tcin);
        end
        eovf = (sr > 32767) || (sr < -32768);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                          input logic tsub, input int hold, input bit early);
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
        int           n;
        bit           bad;
        model(ta, tb_, tcin, tsub, esum, ecout, eovf);

        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_ready", in_ready, 1);

        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        if (early) out_ready = 1'b1;

        n = 0;
        bad = 1'b0;
        while (out_valid !== 1'b1 && n < 50) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("latency", n, NIB);
        chk("run_ready_busy", {31'd0, bad}, 0);
        chk("sum", sum, esum);
        chk("cout", cout, ecout);
        chk("ovf", ovf, eovf);
        chk("done_busy_ready", {busy, in_ready}, 2'b10);

        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
                @(negedge clk);
                chk("hold_valid_ready", {out_valid, in_ready}, 2'b10);
                chk("hold_result", {sum, cout, ovf}, {esum, ecout, eovf});
            end
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_state", {out_valid, in_ready, busy}, 3'b010);
        chk("idle_result_kept", {sum, cout, ovf}, {esum, ecout, eovf});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_ctrl", {in_ready, out_valid, busy}, 3'b100);
        chk("reset_data", {sum, cout, ovf}, {W'(0), 1'b0, 1'b0});

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 5, 1'b0);
        run_op(16'h0000, 16'h8000, 1'b0, 1'b1, 0, 1'b1);

        // Abort: reset lands while the third nibble is being processed.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ctrl", {in_ready, out_valid, busy}, 3'b100);
        chk("abort_sum", sum, 0);
        repeat (NIB + 1) @(negedge clk);
        chk("abort_no_result", {out_valid, in_ready}, 2'b01);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
